// File: rtl/dot_product_acc_pkg.sv
// Shared types and sizing helpers for the dot_product_acc slice.
package dot_product_acc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      HOLD
   } state_t;

   // Width of the carry-save pair: one full product plus growth for the N-way sum.
   function automatic int cs_width(input int in_size_0, input int in_size_1, input int size_array);
      return in_size_0 + in_size_1 + $clog2(size_array);
   endfunction

   // Partial-product count of a radix-8 Booth multiplier array over one beat.
   function automatic int num_pp(input int in_size_1, input int size_array);
      return ((in_size_1 + 2) / 3) * size_array;
   endfunction

endpackage

// File: rtl/dot_product_acc_if.sv
// Operand stream in / result stream out of the dot-product accumulator.
interface dot_product_acc_if #(
   parameter int IN_SIZE_0  = 4,
   parameter int IN_SIZE_1  = 8,
   parameter int SIZE_ARRAY = 8,
   parameter int ACC_SIZE   = 24,
   parameter int MAX_BEATS  = 16
) ();
   import dot_product_acc_pkg::*;

   logic                                  in_valid_i;
   logic                                  in_ready_o;
   logic [SIZE_ARRAY-1:0][IN_SIZE_0-1:0]  in_0_i;
   logic [SIZE_ARRAY-1:0][IN_SIZE_1-1:0]  in_1_i;
   logic                                  in_last_i;
   logic                                  out_valid_o;
   logic                                  out_ready_i;
   logic [ACC_SIZE-1:0]                   out_data_o;
   logic [$clog2(MAX_BEATS+1)-1:0]        out_beats_o;
   logic                                  out_sat_o;

   // Producer of operands / consumer of results.
   modport master (
      output in_valid_i, in_0_i, in_1_i, in_last_i, out_ready_i,
      input  in_ready_o, out_valid_o, out_data_o, out_beats_o, out_sat_o
   );

   // The accumulator itself.
   modport slave (
      input  in_valid_i, in_0_i, in_1_i, in_last_i, out_ready_i,
      output in_ready_o, out_valid_o, out_data_o, out_beats_o, out_sat_o
   );

endinterface

// File: rtl/dot_product_acc_csa_tree_n.sv
// N-input to 2-output carry-save compressor over sign-extended operands.
module csa_tree_n
   import dot_product_acc_pkg::*;
#(
   parameter int IN_SIZE  = 12,
   parameter int OUT_SIZE = 15,
   parameter int N        = 8
) (
   input  logic [N-1:0][IN_SIZE-1:0] in_i,
   output logic [OUT_SIZE-1:0]       out0_o,
   output logic [OUT_SIZE-1:0]       out1_o
);

   logic [OUT_SIZE-1:0] sum_d;
   logic [OUT_SIZE-1:0] carry_d;
   logic [OUT_SIZE-1:0] ext_d;
   logic [OUT_SIZE-1:0] maj_d;

   // Fold each further operand into the running (sum, carry) pair with a 3:2 stage;
   // the carry bit shifted out of the top is dropped, which is exact modulo 2^OUT_SIZE.
   always_comb begin
      sum_d   = OUT_SIZE'(signed'(in_i[0]));
      carry_d = OUT_SIZE'(signed'(in_i[1]));
      ext_d   = '0;
      maj_d   = '0;
      for (int unsigned i = 2; i < N; i++) begin
         ext_d   = OUT_SIZE'(signed'(in_i[i]));
         maj_d   = (sum_d & carry_d) | (sum_d & ext_d) | (carry_d & ext_d);
         sum_d   = sum_d ^ carry_d ^ ext_d;
         carry_d = maj_d << 1;
      end
      out0_o = sum_d;
      out1_o = carry_d;
   end

endmodule

// File: rtl/dot_product_acc.sv
// Two-stage streaming signed dot-product accumulator.
// S1 registers the carry-save pair of one beat's products; S2 resolves it,
// accumulates, and emits a result on in_last_i or after MAX_BEATS beats.
// Optional: define DOT_PRODUCT_ACC_SATURATE_EN to clamp the accumulator and
// report a sticky per-result saturation flag on out_sat_o.
module dot_product_acc
   import dot_product_acc_pkg::*;
#(
   parameter int IN_SIZE_0  = 4,
   parameter int IN_SIZE_1  = 8,
   parameter int SIZE_ARRAY = 8,
   parameter int ACC_SIZE   = 24,
   parameter int MAX_BEATS  = 16
) (
   input logic              clk_i,
   input logic              rst_i,
   dot_product_acc_if.slave dp_if
);

   localparam int P_W    = IN_SIZE_0 + IN_SIZE_1;
   localparam int CS_W   = cs_width(IN_SIZE_0, IN_SIZE_1, SIZE_ARRAY);
   localparam int BEAT_W = $clog2(MAX_BEATS + 1);

`ifdef DOT_PRODUCT_ACC_SATURATE_EN
   localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
   localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};
   logic signed [ACC_SIZE:0]   acc_wide;
`endif

   logic                         en;
   logic                         in_ready;
   logic                         accept;

   logic [SIZE_ARRAY-1:0][P_W-1:0] prod_d;
   logic [CS_W-1:0]              cs0_d;
   logic [CS_W-1:0]              cs1_d;

   logic signed [CS_W-1:0]       cs0_q;
   logic signed [CS_W-1:0]       cs1_q;
   logic                         s1_valid_q;
   logic                         s1_last_q;

   logic signed [CS_W-1:0]       beat_w;
   logic signed [ACC_SIZE-1:0]   beat_sum;
   logic signed [ACC_SIZE-1:0]   acc_q;
   logic signed [ACC_SIZE-1:0]   acc_d;
   logic [BEAT_W-1:0]            cnt_q;
   logic [BEAT_W-1:0]            cnt_inc;
   logic                         term;
   logic                         sat_q;
   logic                         sat_d;
   logic                         sat_hit;

   state_t                       state_q;
   logic                         out_valid_q;
   logic signed [ACC_SIZE-1:0]   out_data_q;
   logic [BEAT_W-1:0]            out_beats_q;
   logic                         out_sat_q;

   // The whole pipeline advances only when the result register is free or being drained.
   assign en       = !out_valid_q || dp_if.out_ready_i;
   assign in_ready = en && !rst_i;
   assign accept   = dp_if.in_valid_i && in_ready;

   // Signed element-wise products, operands sign-extended to the full product width.
   always_comb begin
      prod_d = '0;
      for (int unsigned i = 0; i < SIZE_ARRAY; i++) begin
         prod_d[i] = P_W'(signed'(dp_if.in_0_i[i])) * P_W'(signed'(dp_if.in_1_i[i]));
      end
   end

   csa_tree_n #(
      .IN_SIZE  (P_W),
      .OUT_SIZE (CS_W),
      .N        (SIZE_ARRAY)
   ) u_csa (
      .in_i   (prod_d),
      .out0_o (cs0_d),
      .out1_o (cs1_d)
   );

   // S1: capture the carry-save pair and last flag of each accepted beat.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         cs0_q      <= '0;
         cs1_q      <= '0;
      end else if (en) begin
         s1_valid_q <= accept;
         if (accept) begin
            cs0_q     <= cs0_d;
            cs1_q     <= cs1_d;
            s1_last_q <= dp_if.in_last_i;
         end
      end
   end

   // S2 arithmetic: resolve the pair at its own width before sign-extending,
   // since cs0/cs1 are only meaningful as a sum modulo 2^CS_W.
   always_comb begin
      beat_w   = cs0_q + cs1_q;
      beat_sum = ACC_SIZE'(beat_w);
      cnt_inc  = cnt_q + BEAT_W'(1);
      term     = s1_last_q || (cnt_inc == BEAT_W'(MAX_BEATS));
      acc_d    = '0;
      sat_hit  = 1'b0;
`ifdef DOT_PRODUCT_ACC_SATURATE_EN
      acc_wide = (ACC_SIZE+1)'(acc_q) + (ACC_SIZE+1)'(beat_sum);
      sat_hit  = acc_wide[ACC_SIZE] ^ acc_wide[ACC_SIZE-1];
      if (!sat_hit) begin
         acc_d = acc_wide[ACC_SIZE-1:0];
      end else if (acc_wide[ACC_SIZE]) begin
         acc_d = ACC_MIN;
      end else begin
         acc_d = ACC_MAX;
      end
`else
      acc_d    = acc_q + beat_sum;
`endif
      sat_d    = sat_q | sat_hit;
   end

   // S2 state, FSM and registered result: accumulate, terminate, hold under backpressure.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_beats_q <= '0;
         out_sat_q   <= 1'b0;
      end else if (en) begin
         if (s1_valid_q && term) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_d;
            out_beats_q <= cnt_inc;
            out_sat_q   <= sat_d;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            state_q     <= dp_if.out_ready_i ? IDLE : HOLD;
         end else begin
            out_valid_q <= 1'b0;
            if (s1_valid_q) begin
               acc_q   <= acc_d;
               cnt_q   <= cnt_inc;
               sat_q   <= sat_d;
               state_q <= ACCUM;
            end else if (state_q == HOLD) begin
               state_q <= (cnt_q == '0) ? IDLE : ACCUM;
            end
         end
      end else begin
         state_q <= HOLD;
      end
   end

   assign dp_if.in_ready_o  = in_ready;
   assign dp_if.out_valid_o = out_valid_q;
   assign dp_if.out_data_o  = out_data_q;
   assign dp_if.out_beats_o = out_beats_q;
   assign dp_if.out_sat_o   = out_sat_q;

endmodule
